// File: rtl/time_unit_counter.sv
// Modular up/down time-unit counter (seconds, minutes, hours) with preset, BCD digits
// and a registered wrap pulse that feeds tick_in of the next unit directly.
module time_unit_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             tick_out,
  output logic             terminal,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_TICK
  } action_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             load_ok;
  logic [7:0]       count_ext;
  action_e          action;

  // Out-of-range presets are rejected so count can never leave 0..MODULUS-1.
  assign load_ok = {1'b0, load_val} < ModExt;

  always_comb begin
    if (clear)               action = ACT_CLEAR;
    else if (load)           action = ACT_LOAD;
    else if (tick_in && en)  action = ACT_TICK;
    else                     action = ACT_HOLD;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    count_d = count_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    unique case (action)
      ACT_CLEAR: count_d = '0;
      ACT_LOAD: begin
        if (load_ok) count_d = load_val;
        else         err_d   = 1'b1;
      end
      ACT_TICK: begin
        if (up_down) begin
          if (count_q == MaxVal) begin
            count_d = '0;
            tick_d  = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            count_d = MaxVal;
            tick_d  = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign count     = count_q;
  assign tick_out  = tick_q;
  assign load_err  = err_q;
  assign count_ext = 8'(count_q);
  assign tens      = 4'(count_ext / 8'd10);
  assign ones      = 4'(count_ext % 8'd10);
  assign terminal  = up_down ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench: a 60-count unit with a 24-count unit cascaded on its tick_out,
// compared against an arithmetic model of the counting rules.
module tb_time_unit_counter;

  localparam int MOD  = 60;
  localparam int HMOD = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0, tick_in = 1'b0, en = 1'b0, up_down = 1'b1;
  logic       clear = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] count;
  logic [3:0] tens, ones;
  logic       tick_out, terminal, load_err;

  logic       h_clear = 1'b0, h_en = 1'b1, h_up = 1'b1, h_load = 1'b0;
  logic [4:0] h_load_val = '0;
  logic [4:0] h_count;
  logic [3:0] h_tens, h_ones;
  logic       h_tick_out, h_terminal, h_load_err;

  int checks = 0;
  int failures = 0;
  int mc = 0;
  bit mt = 1'b0;
  bit me = 1'b0;

  always #5 clk = ~clk;

  time_unit_counter #(.MODULUS(MOD), .WIDTH(6)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up_down(up_down),
    .clear(clear), .load(load), .load_val(load_val), .count(count),
    .tens(tens), .ones(ones), .tick_out(tick_out), .terminal(terminal),
    .load_err(load_err)
  );

  time_unit_counter #(.MODULUS(HMOD), .WIDTH(5)) hours (
    .clk(clk), .rst(rst), .tick_in(tick_out), .en(h_en), .up_down(h_up),
    .clear(h_clear), .load(h_load), .load_val(h_load_val), .count(h_count),
    .tens(h_tens), .ones(h_ones), .tick_out(h_tick_out), .terminal(h_terminal),
    .load_err(h_load_err)
  );

  // Advance the reference model by the current inputs, then clock and settle.
  task automatic cycle();
    int nxt;
    mt = 1'b0;
    me = 1'b0;
    if (rst) mc = 0;
    else if (clear) mc = 0;
    else if (load) begin
      if (int'(load_val) < MOD) mc = int'(load_val);
      else me = 1'b1;
    end else if (tick_in && en) begin
      nxt = up_down ? (mc + 1) % MOD : (mc + MOD - 1) % MOD;
      mt  = up_down ? (nxt == 0) : (nxt == MOD - 1);
      mc  = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clear = 1'b0; load = 1'b0; tick_in = 1'b0; h_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_in = 1'b1; clear = 1'b1; load = 1'b1; load_val = 6'd10;
    en = 1'b1; up_down = 1'b1;
    cycle();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (tick_out !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_err); end
    checks++; if (h_count !== 5'd0) begin failures++; $display("FAIL reset_hours got=%0d exp=0", h_count); end
    idle_inputs();
    cycle();
    checks++; if (count !== 6'd0 || tick_out !== 1'b0) begin
      failures++; $display("FAIL reset_hold got=%0d/%b exp=0/0", count, tick_out);
    end
  endtask

  task automatic test_count_up();
    int wraps = 0;
    idle_inputs(); en = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      for (int g = 0; g < int'($urandom_range(2)); g++) begin
        cycle();
        checks++; if (count !== 6'(mc) || tick_out !== 1'b0) begin
          failures++; $display("FAIL up_idle got=%0d/%b exp=%0d/0", count, tick_out, mc);
        end
      end
      tick_in = 1'b1;
      cycle();
      tick_in = 1'b0;
      if (tick_out === 1'b1) wraps++;
      checks++; if (count !== 6'(mc)) begin failures++; $display("FAIL up_count tick=%0d got=%0d exp=%0d", i, count, mc); end
      checks++; if (tick_out !== mt) begin failures++; $display("FAIL up_tick tick=%0d got=%b exp=%b", i, tick_out, mt); end
      checks++; if (tens !== 4'(mc / 10) || ones !== 4'(mc % 10)) begin
        failures++; $display("FAIL up_bcd tick=%0d got=%0d%0d exp=%0d", i, tens, ones, mc);
      end
      if (i == 59) begin
        checks++; if (count !== 6'd59 || tens !== 4'd5 || ones !== 4'd9 || terminal !== 1'b1) begin
          failures++; $display("FAIL up_at59 got=%0d %0d/%0d term=%b exp=59 5/9 1", count, tens, ones, terminal);
        end
      end
      if (i == 60) begin
        checks++; if (count !== 6'd0 || tick_out !== 1'b1) begin
          failures++; $display("FAIL up_wrap got=%0d/%b exp=0/1", count, tick_out);
        end
      end
    end
    checks++; if (wraps != 1) begin failures++; $display("FAIL up_wrap_count got=%0d exp=1", wraps); end
  endtask

  task automatic test_count_down();
    idle_inputs(); en = 1'b1; up_down = 1'b0;
    #1;
    checks++; if (terminal !== 1'b1) begin failures++; $display("FAIL down_term0 got=%b exp=1", terminal); end
    tick_in = 1'b1;
    cycle();
    checks++; if (count !== 6'd59 || tick_out !== 1'b1 || mc != 59) begin
      failures++; $display("FAIL down_wrap got=%0d/%b exp=59/1", count, tick_out);
    end
    cycle();
    tick_in = 1'b0;
    checks++; if (count !== 6'd58 || tick_out !== 1'b0) begin
      failures++; $display("FAIL down_next got=%0d/%b exp=58/0", count, tick_out);
    end
    up_down = 1'b1;
    cycle();
    checks++; if (count !== 6'd58 || tick_out !== 1'b0) begin
      failures++; $display("FAIL dir_change_hold got=%0d/%b exp=58/0", count, tick_out);
    end
  endtask

  task automatic test_load();
    idle_inputs(); en = 1'b1; up_down = 1'b1;
    load = 1'b1; load_val = 6'd45; tick_in = 1'b1;
    cycle();
    checks++; if (count !== 6'd45 || tick_out !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL load_45 got=%0d/%b/%b exp=45/0/0", count, tick_out, load_err);
    end
    tick_in = 1'b0; load_val = 6'd60;
    cycle();
    checks++; if (count !== 6'd45 || load_err !== 1'b1 || tick_out !== 1'b0) begin
      failures++; $display("FAIL load_60 got=%0d/%b/%b exp=45/1/0", count, load_err, tick_out);
    end
    load = 1'b0;
    cycle();
    checks++; if (count !== 6'd45 || load_err !== 1'b0) begin
      failures++; $display("FAIL load_err_pulse got=%0d/%b exp=45/0", count, load_err);
    end
  endtask

  task automatic test_enable();
    idle_inputs(); up_down = 1'b1;
    load = 1'b1; load_val = 6'd59;
    cycle();
    load = 1'b0; en = 1'b0; tick_in = 1'b1;
    cycle();
    checks++; if (count !== 6'd59 || tick_out !== 1'b0 || terminal !== 1'b1) begin
      failures++; $display("FAIL en0 got=%0d/%b term=%b exp=59/0 1", count, tick_out, terminal);
    end
    en = 1'b1;
    cycle();
    tick_in = 1'b0;
    checks++; if (count !== 6'd0 || tick_out !== 1'b1) begin
      failures++; $display("FAIL en1_wrap got=%0d/%b exp=0/1", count, tick_out);
    end
  endtask

  task automatic test_rst_clear();
    idle_inputs(); en = 1'b1; up_down = 1'b1;
    load = 1'b1; load_val = 6'd59;
    cycle();
    load = 1'b0; tick_in = 1'b1; rst = 1'b1;
    cycle();
    checks++; if (count !== 6'd0 || tick_out !== 1'b0) begin
      failures++; $display("FAIL rst_wrap got=%0d/%b exp=0/0", count, tick_out);
    end
    rst = 1'b0; tick_in = 1'b0;
    cycle();
    checks++; if (tick_out !== 1'b0 || count !== 6'd0) begin
      failures++; $display("FAIL rst_release got=%0d/%b exp=0/0", count, tick_out);
    end
    load = 1'b1; load_val = 6'd59;
    cycle();
    load = 1'b0; clear = 1'b1; tick_in = 1'b1;
    cycle();
    checks++; if (count !== 6'd0 || tick_out !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL clear_wrap got=%0d/%b/%b exp=0/0/0", count, tick_out, load_err);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(63) == 0);
      clear    = ($urandom_range(15) == 0);
      load     = ($urandom_range(7) == 0);
      tick_in  = $urandom_range(1);
      en       = ($urandom_range(3) != 0);
      up_down  = $urandom_range(1);
      load_val = 6'($urandom_range(63));
      cycle();
      checks++; if (count !== 6'(mc)) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, mc); end
      checks++; if (tick_out !== mt) begin failures++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, tick_out, mt); end
      checks++; if (load_err !== me) begin failures++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, load_err, me); end
      checks++; if (tens !== 4'(mc / 10) || ones !== 4'(mc % 10)) begin
        failures++; $display("FAIL rand_bcd i=%0d got=%0d%0d exp=%0d", i, tens, ones, mc);
      end
      checks++; if (terminal !== (up_down ? (mc == MOD - 1) : (mc == 0))) begin
        failures++; $display("FAIL rand_term i=%0d got=%b count=%0d dir=%b", i, terminal, mc, up_down);
      end
    end
    idle_inputs();
  endtask

  task automatic test_cascade();
    int exp_h;
    int pulses = 0;
    idle_inputs(); en = 1'b1; up_down = 1'b1;
    clear = 1'b1; h_clear = 1'b1;
    cycle();
    idle_inputs();
    checks++; if (count !== 6'd0 || h_count !== 5'd0) begin
      failures++; $display("FAIL casc_clear got=%0d/%0d exp=0/0", count, h_count);
    end
    tick_in = 1'b1;
    // The hours unit sees each minute carry one cycle after it is issued.
    for (int k = 1; k <= MOD * HMOD + 1; k++) begin
      cycle();
      exp_h = ((k - 1) / MOD) % HMOD;
      if (h_tick_out === 1'b1) pulses++;
      checks++; if (h_count !== 5'(exp_h)) begin
        failures++; $display("FAIL casc_hours k=%0d got=%0d exp=%0d", k, h_count, exp_h);
      end
      checks++; if (h_tick_out !== (k == MOD * HMOD + 1)) begin
        failures++; $display("FAIL casc_carry k=%0d got=%b", k, h_tick_out);
      end
      if (k == MOD * (HMOD - 1) + 1) begin
        checks++; if (h_tens !== 4'd2 || h_ones !== 4'd3) begin
          failures++; $display("FAIL casc_bcd23 got=%0d/%0d exp=2/3", h_tens, h_ones);
        end
      end
    end
    tick_in = 1'b0;
    checks++; if (pulses != 1) begin failures++; $display("FAIL casc_pulses got=%0d exp=1", pulses); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_enable();
    test_rst_clear();
    test_random();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_unit_counter.md
TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 60: count range 0..MODULUS-1; legal range 2..100.
REQ-002 SHALL have parameter WIDTH, default 6: count width; SHALL satisfy 2^WIDTH >= MODULUS.
REQ-003 SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port tick_in  input  1: single-cycle advance strobe from the lower time unit.
REQ-006 SHALL have port en  input  1: count enable; tick_in is ignored while en=0.
REQ-007 SHALL have port up_down  input  1: direction; 1=increment, 0=decrement.
REQ-008 SHALL have port clear  input  1: synchronous return of count to 0.
REQ-009 SHALL have port load  input  1: synchronous preset strobe for time setting.
REQ-010 SHALL have port load_val  input  WIDTH: preset value, sampled when load=1.
REQ-011 SHALL have port count  output  WIDTH: current count, registered.
REQ-012 SHALL have port tens  output  4: BCD tens digit of count.
REQ-013 SHALL have port ones  output  4: BCD ones digit of count.
REQ-014 SHALL have port tick_out  output  1: registered wrap pulse (carry up / borrow down) to the next unit.
REQ-015 SHALL have port terminal  output  1: next qualifying tick will wrap.
REQ-016 SHALL have port load_err  output  1: registered pulse flagging a rejected load.

Function
REQ-017 Priority each cycle SHALL be: rst > clear > load > (tick_in & en) > hold.
REQ-018 Qualifying tick, up_down=1: count < MODULUS-1 -> count+1, tick_out=0; count == MODULUS-1 -> count=0, tick_out=1.
REQ-019 Qualifying tick, up_down=0: count > 0 -> count-1, tick_out=0; count == 0 -> count=MODULUS-1, tick_out=1.
REQ-020 tick_out SHALL assert on the same clock edge that updates count to the wrapped value, for exactly one cycle.
REQ-021 tick_out SHALL be 0 in every cycle not produced by a wrap per REQ-018/019, including hold, clear, load and en=0.
REQ-022 Load with load_val < MODULUS: count=load_val next cycle, tick_out=0, load_err=0.
REQ-023 Load with load_val >= MODULUS: count unchanged, load_err=1 for one cycle, tick_out=0.
REQ-024 load_err SHALL be 0 in every cycle not produced by REQ-023.
REQ-025 Load or clear coincident with tick_in: the tick SHALL be dropped, not deferred, and no wrap pulse issued.
REQ-026 Clear SHALL set count=0 with tick_out=0 and load_err=0, regardless of direction.
REQ-027 up_down changes SHALL take effect on the next qualifying tick; count SHALL NOT change otherwise.
REQ-028 tens/ones SHALL be combinational from count: tens = count/10, ones = count mod 10; always consistent with count, zero added latency.
REQ-029 terminal SHALL be combinational: (up_down=1 & count==MODULUS-1) | (up_down=0 & count==0), independent of en and tick_in.
REQ-030 count SHALL never hold a value >= MODULUS after reset.
REQ-031 Cascading SHALL be supported: tick_out of one instance drives tick_in of the next (seconds -> minutes -> hours) with no extra glue.

Reset
REQ-032 rst=1 at a clock edge SHALL set count=0, tick_out=0, load_err=0, overriding all other inputs including tick_in, clear and load.
REQ-033 rst asserted mid-count or during a wrap cycle SHALL suppress that cycle's tick_out; no pulse is emitted after reset release without a new qualifying tick.

Verification
REQ-034 MODULUS=60, up_down=1, en=1, 60 tick_in pulses from reset -> count 0..59 then 0; tick_out=1 only on the 60th tick's update; tens/ones=5/9 at count 59.
REQ-035 MODULUS=60, up_down=0, count=0, one tick -> count=59, tick_out=1 one cycle; next tick -> 58, tick_out=0.
REQ-036 load=1, load_val=45 with tick_in=1 same cycle -> count=45, tick_out=0, load_err=0; then load_val=60 -> count stays 45, load_err=1 one cycle.
REQ-037 count=59, en=0, tick_in=1 -> count stays 59, tick_out=0, terminal=1; then en=1 and tick -> count=0, tick_out=1.
REQ-038 count=59, tick_in=1 and rst=1 same cycle -> count=0, tick_out=0; clear=1 with tick at count=59 -> count=0, tick_out=0.
REQ-039 MODULUS=24, WIDTH=5 cascaded under a MODULUS=60 instance, 60x24 lower ticks -> hours 0..23 then 0, single carry per wrap, tens/ones=2/3 at count 23.
